// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the ALU arbiter.
package alu_arb_pkg;
  typedef enum logic [3:0] {ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, SLT = 4'd5} alu_op_e;
  typedef enum logic {IDLE, RESP} arb_state_e;
  localparam logic [31:0] ALU_POISON = 32'hDEADBEEF;
  function automatic logic op_legal(input logic [3:0] op);
    return op == 4'(ADD) || op == 4'(SUB) || op == 4'(AND) || op == 4'(OR) || op == 4'(SLT);
  endfunction
endpackage

// File: rtl/ALU.sv
// ALU: single-cycle 32-bit integer ALU; unknown ops return ALU_POISON.
module ALU
  import alu_arb_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  assign y_o = op_i == 4'(ADD) ? a_i + b_i :
               op_i == 4'(SUB) ? a_i - b_i :
               op_i == 4'(AND) ? a_i & b_i :
               op_i == 4'(OR)  ? a_i | b_i :
               op_i == 4'(SLT) ? {31'd0, a_i < b_i} : ALU_POISON;
endmodule

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, search starts just after last_i.
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [IW-1:0] c;
  always_comb begin
    c = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      c = IW'((int'(last_i) + k) % N);
      if (!any_o && req_i[c]) begin
        any_o = 1'b1;
        idx_o = c;
      end
    end
    gnt_o = any_o ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between NREQ requesters, one op in flight.
// Define ALU_ARB_ERR_EN to add the registered resp_err illegal-op flag.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*4-1:0] req_op,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]   resp_valid,
  input  logic [NREQ-1:0]   resp_ready,
`ifdef ALU_ARB_ERR_EN
  output logic              resp_err,
`endif
  output logic [31:0]       resp_data
);
  arb_state_e state_q, state_d;
  logic [IDW-1:0] own_q, own_d, last_q, last_d, idx;
  logic [NREQ-1:0] valid_q, valid_d, gnt;
  logic [31:0] data_q, data_d, alu_y;
  logic [3:0] op;
  logic any, hs, acc;
  rr_pick #(.N(NREQ)) u_pick (.req_i(req_valid), .last_i(last_q), .gnt_o(gnt), .idx_o(idx), .any_o(any));
  assign op = req_op[idx*4 +: 4];
  ALU u_alu (.op_i(op), .a_i(req_a[idx*32 +: 32]), .b_i(req_b[idx*32 +: 32]), .y_o(alu_y));
  // A held result frees the ALU in the same cycle its owner consumes it.
  assign hs = state_q == RESP && resp_ready[own_q];
  assign acc = !rst && any && (state_q == IDLE || hs);
  assign req_ready = acc ? gnt : '0;
  assign resp_valid = valid_q;
  assign resp_data = data_q;
  always_comb begin
    state_d = acc ? RESP : hs ? IDLE : state_q;
    own_d = acc ? idx : own_q;
    last_d = acc ? idx : last_q;
    valid_d = acc ? gnt : hs ? '0 : valid_q;
    data_d = acc ? alu_y : data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      own_q <= '0;
      last_q <= IDW'(NREQ - 1);
      valid_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      own_q <= own_d;
      last_q <= last_d;
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end
`ifdef ALU_ARB_ERR_EN
  logic err_q, err_d;
  assign err_d = acc ? !op_legal(op) : err_q;
  assign resp_err = err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else err_q <= err_d;
  end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter (2 requesters).
module tb_alu_arbiter;
  localparam int N = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, resp_valid, resp_ready = '0;
  logic [N*4-1:0] req_op = '0;
  logic [N*32-1:0] req_a = '0, req_b = '0;
  logic [31:0] resp_data;
  logic resp_err_w;
`ifdef ALU_ARB_ERR_EN
  logic resp_err;
  assign resp_err_w = resp_err;
`else
  assign resp_err_w = 1'b0;
`endif
  alu_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid),
    .resp_ready(resp_ready),
`ifdef ALU_ARB_ERR_EN
    .resp_err(resp_err),
`endif
    .resp_data(resp_data));
  always #5 clk = ~clk;
  typedef struct {logic [N-1:0] v; logic [31:0] d; logic e;} exp_t;
  exp_t sb[$];
  logic [N-1:0] exp_rv = '0;
  logic [31:0] exp_d = '0;
  logic exp_e = 1'b0;
  int pass_cnt = 0, total = 0;
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd5: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'hDEADBEEF;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic set_req(input int p, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid[p] = v;
    req_op[4*p +: 4] = op;
    req_a[32*p +: 32] = a;
    req_b[32*p +: 32] = b;
  endtask
  // Runs one clock: checks the grant, queues the expected result, then checks the response side.
  task automatic cyc(input string tag, input logic [N-1:0] g);
    exp_t e;
    logic hs;
    int p;
    #1;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'(g));
    if (g != '0) begin
      p = 0;
      for (int i = 0; i < N; i++) if (g[i]) p = i;
      e.v = g;
      e.d = model(req_op[4*p +: 4], req_a[32*p +: 32], req_b[32*p +: 32]);
      e.e = !(req_op[4*p +: 4] inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5});
      sb.push_back(e);
    end
    hs = (exp_rv & resp_ready) != '0;
    @(posedge clk);
    #1;
    if (g != '0) begin
      e = sb.pop_front();
      exp_rv = e.v;
      exp_d = e.d;
      exp_e = e.e;
    end else if (hs) exp_rv = '0;
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(exp_rv));
    chk({tag, ".resp_data"}, resp_data, exp_d);
`ifdef ALU_ARB_ERR_EN
    if (g != '0) chk({tag, ".resp_err"}, 32'(resp_err_w), 32'(exp_e));
`endif
  endtask
  initial begin
    #1;
    chk("rst.req_ready", 32'(req_ready), 0);
    chk("rst.resp_valid", 32'(resp_valid), 0);
    chk("rst.resp_data", resp_data, 0);
    chk("rst.resp_err", 32'(resp_err_w), 0);
    @(negedge clk);
    rst = 1'b0;
    resp_ready = '1;
    set_req(0, 1'b1, 4'd1, 32'd10, 32'd3);
    set_req(1, 1'b1, 4'd2, 32'hF0, 32'h3C);
    cyc("rr0", 2'b01);
    chk("rr0.val", resp_data, 32'd7);
    cyc("rr1", 2'b10);
    chk("rr1.val", resp_data, 32'h30);
    cyc("rr2", 2'b01);
    cyc("rr3", 2'b10);
    req_valid = '0;
    cyc("drain0", 2'b00);
    set_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
    cyc("single", 2'b01);
    chk("single.val", resp_data, 32'd12);
    req_valid = '0;
    cyc("drain1", 2'b00);
    resp_ready = '0;
    set_req(1, 1'b1, 4'd5, 32'd2, 32'd9);
    cyc("bp", 2'b10);
    chk("bp.val", resp_data, 32'd1);
    req_valid = '0;
    set_req(0, 1'b1, 4'd0, 32'd1, 32'd1);
    for (int i = 0; i < 4; i++) cyc("bp.hold", 2'b00);
    resp_ready = '1;
    cyc("bp.release", 2'b01);
    chk("bp.next", resp_data, 32'd2);
    req_valid = '0;
    cyc("drain2", 2'b00);
    set_req(0, 1'b1, 4'd0, 32'hFFFFFFFF, 32'd1);
    set_req(1, 1'b1, 4'd1, 32'd0, 32'd1);
    cyc("wrap.sub", 2'b10);
    chk("wrap.sub.val", resp_data, 32'hFFFFFFFF);
    req_valid[1] = 1'b0;
    cyc("wrap.add", 2'b01);
    chk("wrap.add.val", resp_data, 32'd0);
    set_req(0, 1'b1, 4'd7, 32'd1, 32'd2);
    cyc("illegal", 2'b01);
    chk("illegal.val", resp_data, 32'hDEADBEEF);
    set_req(0, 1'b1, 4'd0, 32'd3, 32'd4);
    cyc("legal", 2'b01);
    req_valid = '0;
    resp_ready = '0;
    set_req(0, 1'b1, 4'd0, 32'd3, 32'd4);
    cyc("pre_rst", 2'b00);
    req_valid = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst.resp_valid", 32'(resp_valid), 0);
    chk("arst.resp_data", resp_data, 0);
    chk("arst.req_ready", 32'(req_ready), 0);
    chk("arst.resp_err", 32'(resp_err_w), 0);
    sb.delete();
    exp_rv = '0;
    exp_d = '0;
    exp_e = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    resp_ready = '1;
    set_req(0, 1'b1, 4'd3, 32'h0F, 32'hF0);
    set_req(1, 1'b1, 4'd0, 32'd1, 32'd1);
    cyc("post_rst", 2'b01);
    chk("post_rst.val", resp_data, 32'hFF);
    req_valid = '0;
    cyc("drain3", 2'b00);
    chk("sb.empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single-cycle integer ALU between `NREQ` independent requesters, e.g. the execute stage, the address-generation unit and a debug port. Round-robin arbitration, valid/ready handshake on both the request and response sides, and a registered result with one operation in flight at a time. Sits between the requesters and one instance of the existing `ALU` module.

## Interface
- `NREQ`, default 2: number of requesters, legal range 2..8.
- `IDW`, derived as `$clog2(NREQ)`: width of the grant index.

Ports:
- `clk` input, 1: clock, rising edge.
- `rst` input, 1: reset, asynchronous, active-high.
- `req_valid` input, NREQ: request pending, one bit per requester.
- `req_ready` output, NREQ: request accepted this cycle (one-hot or zero).
- `req_op` input, NREQ*4: ALU select per requester; slice i is `[4*i+3:4*i]`.
- `req_a` input, NREQ*32: operand A per requester.
- `req_b` input, NREQ*32: operand B per requester.
- `resp_valid` output, NREQ: result valid for requester i (one-hot or zero).
- `resp_ready` input, NREQ: requester i consumes the result.
- `resp_data` output, 32: registered ALU result, shared by all requesters.
- `resp_err` output, 1: present only with `ALU_ARB_ERR_EN`; op was not a legal encoding.

## Operation
- FSM states:
  - IDLE: no result held.
  - RESP: result held for owner `own_q`.
- Grant selection:
  - Round-robin over requesters with `req_valid` high.
  - Search starts at `last_q+1` and wraps modulo NREQ.
  - `last_q` resets to NREQ-1, so requester 0 wins the first contest.
- Accept condition:
  - Accept when state is IDLE, or when state is RESP and `resp_valid[own_q] && resp_ready[own_q]` (back-to-back).
  - On accept: `req_ready[g]`=1, operands and op of winner g drive the ALU, and the result is registered into `resp_data`.
  - On accept: `own_q`←g, `last_q`←g, state←RESP.
- RESP with handshake and no new grant → IDLE.
- RESP without handshake → hold all state. `resp_data` must be stable while `resp_valid` is high.
- Ops follow the ALU encoding:
  - 0 add, 1 sub, 2 and, 3 or, 5 slt (unsigned compare).
  - Any other op passes through; the ALU returns 32'hDEADBEEF and the arbiter does not alter it.
- Arithmetic wraps modulo 2^32. There is no carry or overflow output.
- A requester must hold `req_valid` and its payload until `req_ready`. Dropping `req_valid` before grant is permitted and simply withdraws the request.
- `req_ready` is never asserted to a requester with `req_valid` low.

## Timing
- Reset values:
  - state=IDLE, `req_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_err`=0.
  - `own_q`=0, `last_q`=NREQ-1.
- Latency: request accepted at edge N; `resp_valid[g]` and `resp_data` are visible after edge N, i.e. one cycle.
- Throughput: one op per cycle when the owner holds `resp_ready` high. Otherwise stalled until the handshake.
- `req_ready` is combinational from `req_valid`, state, `resp_ready` and `last_q`. `resp_*` outputs are registered.
- Simultaneous response handshake and new request from the same requester: that requester is eligible, and round-robin still applies.
- Reset asserted mid-operation: the held result is discarded immediately and the request is not replayed.

## Configuration
- `ALU_ARB_ERR_EN` defined:
  - `resp_err` port exists, registered alongside `resp_data`.
  - It is 1 when the accepted op is not in {0,1,2,3,5}.
- `ALU_ARB_ERR_EN` undefined: port and logic are absent; everything else is identical.

## Structure
- Package `alu_arb_pkg` holds:
  - `alu_op_e` enum (ADD=0, SUB=1, AND=2, OR=3, SLT=5).
  - `arb_state_e` (IDLE, RESP).
  - `ALU_POISON`=32'hDEADBEEF.
- Sub-module `rr_pick` is natural and reusable: a purely combinational round-robin picker taking the request vector and last index, returning the grant one-hot and the index.
- The top instantiates `rr_pick` and one `ALU`.

## Test plan
- Single request on port 0: op=0, a=5, b=7 → `req_ready[0]` for one cycle; next cycle `resp_valid[0]`=1 and `resp_data`=12.
- Both ports valid continuously, `resp_ready`=all ones:
  - Port 0 sub 10-3, port 1 and F0&3C.
  - Grants alternate 0,1,0,1; results are 7 and 0x30 on successive cycles; one op per cycle.
- Backpressure:
  - Port 1 slt 2<9, `resp_ready[1]`=0 for 4 cycles.
  - `resp_valid[1]` and `resp_data`=1 stay stable; no `req_ready` to anyone until the handshake.
- Wrap-around: 0xFFFFFFFF+1 → 0, and 0-1 → 0xFFFFFFFF.
- Illegal op=7 → `resp_data`=0xDEADBEEF; `resp_err`=1 with `ALU_ARB_ERR_EN`, port absent without it.
- Reset mid-RESP with `resp_ready` low → all outputs return to reset values asynchronously. After release, requester 0 wins first when all are valid.
